// File: rtl/egress_tag_alloc_if.sv
// rtl/egress_tag_alloc_if.sv - tag allocate/publish/release handshake bundle
interface egress_tag_alloc_if #(
  parameter int TAG_W = 5,
  parameter int DST_W = 2
);
  logic                   alloc_valid;
  logic [DST_W-1:0]       alloc_dst;
  logic                   alloc_rdy;
  logic [TAG_W-1:0]       alloc_tag;
  logic [TAG_W+DST_W-1:0] tag;
  logic                   tag_vld;
  logic                   rel_valid;
  logic [TAG_W-1:0]       rel_tag;

  modport master (
    output alloc_valid, alloc_dst, rel_valid, rel_tag,
    input  alloc_rdy, alloc_tag, tag, tag_vld
  );

  modport slave (
    input  alloc_valid, alloc_dst, rel_valid, rel_tag,
    output alloc_rdy, alloc_tag, tag, tag_vld
  );
endinterface

// File: rtl/egress_tag_alloc.sv
// rtl/egress_tag_alloc.sv - non-posted read tag free list with busy tracking
module egress_tag_alloc #(
  parameter int TAG_W = 5,
  parameter int DST_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  egress_tag_alloc_if.slave   bus,
  output logic [TAG_W:0]      free_cnt,
  output logic                init_done,
  output logic                err_dbl_free
);
  localparam int NUM_TAGS = 1 << TAG_W;
  localparam int T_W      = TAG_W + DST_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    fifo [NUM_TAGS];
  logic [TAG_W:0]      wr_ptr, rd_ptr;
  logic [NUM_TAGS-1:0] busy;
  logic [TAG_W-1:0]    init_cnt;
  logic [TAG_W-1:0]    head;
  logic                rdy, grant, rel_ok, push;
  logic [TAG_W-1:0]    push_tag;
  logic [T_W-1:0]      tag_q;
  logic                tag_vld_q;

  // Occupancy falls out of the extended pointers, so no separate counter to keep coherent.
  assign free_cnt      = wr_ptr - rd_ptr;
  assign head          = fifo[rd_ptr[TAG_W-1:0]];
  assign bus.alloc_rdy = rdy;
  assign bus.alloc_tag = head;
  assign bus.tag       = tag_q;
  assign bus.tag_vld   = tag_vld_q;

  always_comb begin
    state_d  = state_q;
    rdy      = 1'b0;
    grant    = 1'b0;
    rel_ok   = 1'b0;
    push     = 1'b0;
    push_tag = bus.rel_tag;
    case (state_q)
      S_INIT: begin
        push     = 1'b1;
        push_tag = init_cnt;
        if (init_cnt == TAG_W'(NUM_TAGS - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        rdy    = (free_cnt != '0);
        grant  = bus.alloc_valid & rdy;
        // Busy is sampled before this cycle's grant, so releasing the tag being granted is an error.
        rel_ok = bus.rel_valid & busy[bus.rel_tag];
        push   = rel_ok;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[TAG_W-1:0]] <= push_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      busy         <= '0;
      init_cnt     <= '0;
      init_done    <= 1'b0;
      tag_q        <= '0;
      tag_vld_q    <= 1'b0;
      err_dbl_free <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_done    <= (state_d == S_RUN);
      err_dbl_free <= bus.rel_valid & ~busy[bus.rel_tag];
      tag_vld_q    <= grant;
      if (state_q == S_INIT) init_cnt <= init_cnt + TAG_W'(1);
      if (push) wr_ptr <= wr_ptr + (TAG_W+1)'(1);
      if (grant) begin
        rd_ptr     <= rd_ptr + (TAG_W+1)'(1);
        busy[head] <= 1'b1;
        tag_q      <= {bus.alloc_dst, head};
      end
      if (rel_ok) busy[bus.rel_tag] <= 1'b0;
    end
  end
endmodule
